surov_mem_bridge: RTL and testbench
===================================

# surov_mem_bridge

Memory-side stage downstream of the surov core. It takes the core's sub-word load/store requests (byte/half/word, any alignment) and turns them into word-aligned transactions with byte enables on a request/grant/rvalid system bus. Misaligned accesses are split into two bus transactions, and read data is merged and right-justified before it is returned. The core holds each request until `mem_ready`, and performs sign extension itself.

## Interface
- `XLEN`, 32: data/address width; only 32 is supported.
- `SPLIT_MISALIGNED`, 1: 1 = split word-crossing accesses; 0 = reject them with `mem_misaligned`, no bus traffic.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous reset, active-low (asserted at 0).
- `mem_addr`  in  32  byte address from core.
- `mem_rden` / `mem_wren`  in  1  load / store request, held until `mem_ready`.
- `mem_size`  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- `memwrite_data`  in  32  store data, right-justified.
- `memread_data`  out  32  load data, right-justified, zero-extended; valid while `mem_ready`=1.
- `mem_ready`  out  1  one-cycle completion pulse.
- `mem_misaligned`  out  1  one-cycle pulse, only with `SPLIT_MISALIGNED`=0; coincides with `mem_ready`.
- `bus_req`  out  1  transaction request, held until `bus_gnt`.
- `bus_we`  out  1  1 = write.
- `bus_addr`  out  32  word-aligned address; bits [1:0] are always 0.
- `bus_be`  out  4  byte enables.
- `bus_wdata`  out  32  lane-aligned write data.
- `bus_gnt`  in  1  request accepted this cycle.
- `bus_rvalid`  in  1  read data valid.
- `bus_rdata`  in  32  read word.

## Operation
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- Request sampling (IDLE only):
  - On `mem_rden|mem_wren`, capture address, size, write data, and we. If both are set, we = 1 (write wins).
  - Compute n (bytes = 1/2/4), off = `addr[1:0]`, and split = off+n>4.
- Rejected access: if split and `SPLIT_MISALIGNED`=0, go to RESP with `mem_misaligned`=1 and `memread_data`=0. No bus traffic.
- Lane computation:
  - Word 0: `bus_addr` = {addr[31:2],2'b00}; `bus_be` = (((1<<n)-1)<<off)[3:0]; `bus_wdata` = wdata<<(8·off).
  - Word 1: `bus_addr` = word 0 + 4, wrapping 0xFFFFFFFC→0x00000000; `bus_be` = ((1<<n)-1)>>(4−off); `bus_wdata` = wdata>>(8·(4−off)).
- REQ0 / REQ1:
  - `bus_req`=1 with all bus fields stable until the `bus_gnt` cycle.
  - Write on grant: go to REQ1 if split and in REQ0, otherwise RESP.
  - Read on grant: go to WAITx. If `bus_rvalid` arrives in the same cycle as `bus_gnt`, capture it and skip WAITx.
- WAIT0 / WAIT1:
  - On `bus_rvalid`, capture `bus_rdata` into lo (WAIT0) or hi (WAIT1).
  - Then go to REQ1 if split and in WAIT0, otherwise RESP.
- Read merge: `memread_data` = ({hi,lo}>>(8·off)) masked to n bytes. hi = 0 if not split.
- RESP:
  - `mem_ready`=1 for exactly one cycle, then IDLE.
  - Core request levels during RESP are ignored.
  - A request still high in the following IDLE cycle is a new request.
- `bus_rvalid` outside WAITx, or in the same cycle as `bus_gnt` for a write, is ignored.
- `bus_gnt` while `bus_req`=0 is ignored.
- Captured request fields are not updated while busy; the core's inputs may change freely.

## Timing
- All outputs are registered.
- Reset (`rst`=0) asynchronously forces IDLE and clears every output to 0. Captured buffers clear too.
  - Reset mid-transaction abandons it; a late `bus_rvalid` is then ignored.
- Request sampled at edge T; `bus_req` is visible in cycle T+1.
- Zero-wait grant, rvalid one cycle after grant:
  - Aligned read: `mem_ready` in T+3.
  - Aligned write: `mem_ready` in T+2.
  - Split read: T+5; split write: T+3.
- Same-cycle grant+rvalid removes one cycle per word.
- Each bus wait cycle adds exactly one cycle.
- Rejected misaligned access: `mem_ready` in T+1.
- Throughput: at most one core request in flight. Minimum gap from `mem_ready` to the next `bus_req` is 2 cycles.

## Test plan
- Aligned word read, addr 0x100, bus returns 0xDEADBEEF one cycle after grant → single transaction, `bus_be`=4'hF; `mem_ready` at T+3 with 0xDEADBEEF.
- Byte store 0xAB at addr 0x203 → `bus_addr`=0x200, `bus_be`=4'b1000, `bus_wdata`=0xAB000000; `mem_ready` at T+2.
- Half read at 0x303, words at 0x300=0x11223344 and 0x304=0x55667788 → two transactions, `bus_be` 4'b1000 then 4'b0001; `memread_data`=0x00008811.
- Word store 0xCAFEBABE at 0xFFFFFFFE → 0xFFFFFFFC `be`=4'b1100 `wdata`=0xBABE0000, then 0x00000000 `be`=4'b0011 `wdata`=0x0000CAFE.
- `SPLIT_MISALIGNED`=0, word read at 0x401 → no `bus_req`; `mem_ready` and `mem_misaligned` at T+1; data 0.
- `bus_gnt` withheld 3 cycles, then `rst` pulsed low during WAIT0 → all outputs 0 immediately. A subsequent `bus_rvalid` is ignored; the next request completes normally.

Source files
------------

// File: rtl/surov_mem_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : surov_mem_bridge                                              |
// | Purpose  : Converts the surov core's byte/half/word load-store requests  |
// |            (any alignment) into word-aligned request/grant/rvalid bus    |
// |            transactions with byte enables. Word-crossing accesses are    |
// |            split in two (or rejected when SPLIT_MISALIGNED=0), and load  |
// |            data is merged, right-justified and zero-extended.            |
// | Ports    : clk, rst (async, active-low)                                  |
// |            core side : mem_addr, mem_rden, mem_wren, mem_size,           |
// |                        memwrite_data -> memread_data, mem_ready,         |
// |                        mem_misaligned                                    |
// |            bus side  : bus_req, bus_we, bus_addr, bus_be, bus_wdata,     |
// |                        bus_gnt, bus_rvalid, bus_rdata                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module surov_mem_bridge #(
  parameter int XLEN             = 32,
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] mem_addr,
  input  logic            mem_rden,
  input  logic            mem_wren,
  input  logic [1:0]      mem_size,
  input  logic [XLEN-1:0] memwrite_data,
  output logic [XLEN-1:0] memread_data,
  output logic            mem_ready,
  output logic            mem_misaligned,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [3:0]      bus_be,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_gnt,
  input  logic            bus_rvalid,
  input  logic [XLEN-1:0] bus_rdata
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ0  = 3'd1,
    ST_WAIT0 = 3'd2,
    ST_REQ1  = 3'd3,
    ST_WAIT1 = 3'd4,
    ST_RESP  = 3'd5
  } state_t;

  // Size code 3 behaves as a word everywhere.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'd0:    size_bytes = 3'd1;
      2'd1:    size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] size_lanes(input logic [1:0] sz);
    case (sz)
      2'd0:    size_lanes = 4'b0001;
      2'd1:    size_lanes = 4'b0011;
      default: size_lanes = 4'b1111;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] size_dmask(input logic [1:0] sz);
    case (sz)
      2'd0:    size_dmask = {{(XLEN-8){1'b0}}, 8'hFF};
      2'd1:    size_dmask = {{(XLEN-16){1'b0}}, 16'hFFFF};
      default: size_dmask = {XLEN{1'b1}};
    endcase
  endfunction

  state_t          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;      // word-aligned address of word 0
  logic [1:0]      off_q, off_d;
  logic [1:0]      size_q, size_d;
  logic            we_q, we_d;
  logic            split_q, split_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] lo_q, lo_d;          // first read word of a split load

  logic [XLEN-1:0] memread_data_q, memread_data_d;
  logic            mem_ready_q, mem_ready_d;
  logic            mem_misaligned_q, mem_misaligned_d;
  logic            bus_req_q, bus_req_d;
  logic            bus_we_q, bus_we_d;
  logic [XLEN-1:0] bus_addr_q, bus_addr_d;
  logic [3:0]      bus_be_q, bus_be_d;
  logic [XLEN-1:0] bus_wdata_q, bus_wdata_d;

  // Word-0 lanes come straight from the core inputs at sample time.
  logic [1:0]      in_off;
  logic            in_split;
  logic [3:0]      in_be;
  logic [XLEN-1:0] in_wdata;

  assign in_off   = mem_addr[1:0];
  assign in_split = ({1'b0, in_off} + size_bytes(mem_size)) > 3'd4;
  assign in_be    = size_lanes(mem_size) << in_off;
  assign in_wdata = memwrite_data << {in_off, 3'b000};

  // Word-1 lanes are the bytes that spilled past the top of word 0.
  // A shift by the full width (off=0) yields zero, which is never used
  // because an off=0 access cannot split.
  logic [4:0]      off_sh;
  logic [3:0]      w1_be;
  logic [XLEN-1:0] w1_wdata;
  logic [XLEN-1:0] w1_addr;

  assign off_sh   = {off_q, 3'b000};
  assign w1_be    = size_lanes(size_q) >> (3'd4 - {1'b0, off_q});
  assign w1_wdata = wdata_q >> (6'd32 - {1'b0, off_sh});
  assign w1_addr  = addr_q + XLEN'(4);   // wraps 0xFFFFFFFC -> 0

  // Merge of {hi,lo} >> 8*off. While finishing word 0 the incoming data is
  // lo and hi is zero; while finishing word 1 it is hi.
  logic            on_word0;
  logic [XLEN-1:0] rd_lo, rd_hi, rd_merged;

  assign on_word0  = (state_q == ST_REQ0) || (state_q == ST_WAIT0);
  assign rd_lo     = on_word0 ? bus_rdata : lo_q;
  assign rd_hi     = on_word0 ? '0 : bus_rdata;
  assign rd_merged = ((rd_lo >> off_sh) | (rd_hi << (6'd32 - {1'b0, off_sh})))
                     & size_dmask(size_q);

  logic launch1, done_rd, done_wr;

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    off_d            = off_q;
    size_d           = size_q;
    we_d             = we_q;
    split_d          = split_q;
    wdata_d          = wdata_q;
    lo_d             = lo_q;
    memread_data_d   = memread_data_q;
    mem_ready_d      = 1'b0;
    mem_misaligned_d = 1'b0;
    bus_req_d        = bus_req_q;
    bus_we_d         = bus_we_q;
    bus_addr_d       = bus_addr_q;
    bus_be_d         = bus_be_q;
    bus_wdata_d      = bus_wdata_q;
    launch1          = 1'b0;
    done_rd          = 1'b0;
    done_wr          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mem_rden || mem_wren) begin
          addr_d  = {mem_addr[XLEN-1:2], 2'b00};
          off_d   = in_off;
          size_d  = mem_size;
          wdata_d = memwrite_data;
          we_d    = mem_wren;             // write wins when both are set
          split_d = in_split;
          lo_d    = '0;
          if (in_split && !SPLIT_MISALIGNED) begin
            state_d          = ST_RESP;
            mem_ready_d      = 1'b1;
            mem_misaligned_d = 1'b1;
            memread_data_d   = '0;
          end else begin
            state_d     = ST_REQ0;
            bus_req_d   = 1'b1;
            bus_we_d    = mem_wren;
            bus_addr_d  = {mem_addr[XLEN-1:2], 2'b00};
            bus_be_d    = in_be;
            bus_wdata_d = in_wdata;
          end
        end
      end
      ST_REQ0: begin
        if (bus_gnt) begin
          bus_req_d = 1'b0;
          if (we_q) begin
            if (split_q) launch1 = 1'b1;
            else         done_wr = 1'b1;
          end else if (bus_rvalid) begin
            lo_d = bus_rdata;
            if (split_q) launch1 = 1'b1;
            else         done_rd = 1'b1;
          end else begin
            state_d = ST_WAIT0;
          end
        end
      end
      ST_WAIT0: begin
        if (bus_rvalid) begin
          lo_d = bus_rdata;
          if (split_q) launch1 = 1'b1;
          else         done_rd = 1'b1;
        end
      end
      ST_REQ1: begin
        if (bus_gnt) begin
          bus_req_d = 1'b0;
          if (we_q)            done_wr = 1'b1;
          else if (bus_rvalid) done_rd = 1'b1;
          else                 state_d = ST_WAIT1;
        end
      end
      ST_WAIT1: begin
        if (bus_rvalid) done_rd = 1'b1;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (launch1) begin
      state_d     = ST_REQ1;
      bus_req_d   = 1'b1;
      bus_addr_d  = w1_addr;
      bus_be_d    = w1_be;
      bus_wdata_d = w1_wdata;
    end
    if (done_rd) begin
      state_d        = ST_RESP;
      mem_ready_d    = 1'b1;
      memread_data_d = rd_merged;
    end
    if (done_wr) begin
      state_d        = ST_RESP;
      mem_ready_d    = 1'b1;
      memread_data_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= ST_IDLE;
      addr_q           <= '0;
      off_q            <= '0;
      size_q           <= '0;
      we_q             <= 1'b0;
      split_q          <= 1'b0;
      wdata_q          <= '0;
      lo_q             <= '0;
      memread_data_q   <= '0;
      mem_ready_q      <= 1'b0;
      mem_misaligned_q <= 1'b0;
      bus_req_q        <= 1'b0;
      bus_we_q         <= 1'b0;
      bus_addr_q       <= '0;
      bus_be_q         <= '0;
      bus_wdata_q      <= '0;
    end else begin
      state_q          <= state_d;
      addr_q           <= addr_d;
      off_q            <= off_d;
      size_q           <= size_d;
      we_q             <= we_d;
      split_q          <= split_d;
      wdata_q          <= wdata_d;
      lo_q             <= lo_d;
      memread_data_q   <= memread_data_d;
      mem_ready_q      <= mem_ready_d;
      mem_misaligned_q <= mem_misaligned_d;
      bus_req_q        <= bus_req_d;
      bus_we_q         <= bus_we_d;
      bus_addr_q       <= bus_addr_d;
      bus_be_q         <= bus_be_d;
      bus_wdata_q      <= bus_wdata_d;
    end
  end

  assign memread_data   = memread_data_q;
  assign mem_ready      = mem_ready_q;
  assign mem_misaligned = mem_misaligned_q;
  assign bus_req        = bus_req_q;
  assign bus_we         = bus_we_q;
  assign bus_addr       = bus_addr_q;
  assign bus_be         = bus_be_q;
  assign bus_wdata      = bus_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_surov_mem_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_surov_mem_bridge                                           |
// | Purpose  : Directed scoreboard bench for surov_mem_bridge. One instance  |
// |            splits misaligned accesses, a second rejects them.            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_surov_mem_bridge;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct {
    logic [31:0] data;
    logic        chk_data;
    logic        mis;
    int          cyc;
  } resp_exp_t;

  logic        clk, rst;
  logic [31:0] mem_addr, memwrite_data, memread_data;
  logic        mem_rden, mem_wren, mem_ready, mem_misaligned;
  logic [1:0]  mem_size;
  logic        bus_req, bus_we, bus_gnt, bus_rvalid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  logic [31:0] ns_mem_addr, ns_memwrite_data, ns_memread_data;
  logic        ns_mem_rden, ns_mem_wren, ns_mem_ready, ns_mem_misaligned;
  logic [1:0]  ns_mem_size;
  logic        ns_bus_req, ns_bus_we, ns_bus_gnt, ns_bus_rvalid;
  logic [31:0] ns_bus_addr, ns_bus_wdata, ns_bus_rdata;
  logic [3:0]  ns_bus_be;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  bus_exp_t  bus_q[$];
  resp_exp_t resp_q[$];
  resp_exp_t ns_q[$];

  // Bus responder knobs and state
  int          gnt_wait = 0;
  int          rv_lat   = 1;
  int          gw_cnt   = 0;
  bit          rv_pending = 0;
  int          rv_wait  = 0;
  logic [31:0] rv_data  = '0;

  surov_mem_bridge #(.XLEN(32), .SPLIT_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst(rst),
    .mem_addr(mem_addr), .mem_rden(mem_rden), .mem_wren(mem_wren),
    .mem_size(mem_size), .memwrite_data(memwrite_data),
    .memread_data(memread_data), .mem_ready(mem_ready),
    .mem_misaligned(mem_misaligned),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata)
  );

  surov_mem_bridge #(.XLEN(32), .SPLIT_MISALIGNED(1'b0)) dut_ns (
    .clk(clk), .rst(rst),
    .mem_addr(ns_mem_addr), .mem_rden(ns_mem_rden), .mem_wren(ns_mem_wren),
    .mem_size(ns_mem_size), .memwrite_data(ns_memwrite_data),
    .memread_data(ns_memread_data), .mem_ready(ns_mem_ready),
    .mem_misaligned(ns_mem_misaligned),
    .bus_req(ns_bus_req), .bus_we(ns_bus_we), .bus_addr(ns_bus_addr),
    .bus_be(ns_bus_be), .bus_wdata(ns_bus_wdata), .bus_gnt(ns_bus_gnt),
    .bus_rvalid(ns_bus_rvalid), .bus_rdata(ns_bus_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500000, required completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h0000_0100: mem_rd = 32'hDEAD_BEEF;
      32'h0000_0300: mem_rd = 32'h1122_3344;
      32'h0000_0304: mem_rd = 32'h5566_7788;
      32'h0000_0500: mem_rd = 32'hA5A5_A5A5;
      default:       mem_rd = 32'h0000_0000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Bus slave: drives gnt/rvalid just after each rising edge.
  initial begin
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    forever begin
      @(posedge clk); #1;
      bus_gnt    = 1'b0;
      bus_rvalid = 1'b0;
      bus_rdata  = 32'h0BAD_F00D;
      if (rv_pending) begin
        if (rv_wait == 0) begin
          bus_rvalid = 1'b1;
          bus_rdata  = rv_data;
          rv_pending = 1'b0;
        end else begin
          rv_wait--;
        end
      end
      if (bus_req) begin
        if (gw_cnt == gnt_wait) begin
          bus_gnt = 1'b1;
          gw_cnt  = 0;
          if (!bus_we) begin
            if (rv_lat == 0) begin
              bus_rvalid = 1'b1;
              bus_rdata  = mem_rd(bus_addr);
            end else begin
              rv_pending = 1'b1;
              rv_wait    = rv_lat - 1;
              rv_data    = mem_rd(bus_addr);
            end
          end
        end else begin
          gw_cnt++;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT hands something over.
  initial begin : monitor
    bus_exp_t  eb;
    resp_exp_t er;
    forever begin
      @(negedge clk);
      if (bus_req && bus_gnt) begin
        if (bus_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL bus_unexpected: got transaction at 0x%08h required none", bus_addr);
        end else begin
          eb = bus_q.pop_front();
          chk("bus_we",    {31'd0, bus_we}, {31'd0, eb.we});
          chk("bus_addr",  bus_addr, eb.addr);
          chk("bus_be",    {28'd0, bus_be}, {28'd0, eb.be});
          chk("bus_wdata", bus_wdata, eb.wdata);
        end
      end
      if (mem_ready) begin
        if (resp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL ready_unexpected: got mem_ready at cycle %0d required none", cyc);
        end else begin
          er = resp_q.pop_front();
          if (er.chk_data) chk("read_data", memread_data, er.data);
          chk("misaligned",  {31'd0, mem_misaligned}, {31'd0, er.mis});
          chk("ready_cycle", cyc, er.cyc);
        end
      end
      if (ns_mem_ready) begin
        if (ns_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL ns_ready_unexpected: got mem_ready at cycle %0d required none", cyc);
        end else begin
          er = ns_q.pop_front();
          chk("ns_read_data",   ns_memread_data, er.data);
          chk("ns_misaligned",  {31'd0, ns_mem_misaligned}, {31'd0, er.mis});
          chk("ns_ready_cycle", cyc, er.cyc);
        end
      end
      if (ns_bus_req) begin
        checks++; failures++;
        $display("FAIL ns_bus_req: got 1 at cycle %0d required 0", cyc);
      end
    end
  end

  task automatic push_bus(input logic we, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] wd);
    bus_q.push_back('{we: we, addr: a, be: be, wdata: wd});
  endtask

  // Issue one core request, held until mem_ready, from just after a rising edge.
  task automatic do_req(input bit we, input bit both, input logic [31:0] a,
                        input logic [1:0] sz, input logic [31:0] wd,
                        input bit cd, input logic [31:0] ed, input int lat);
    bit got;
    resp_q.push_back('{data: ed, chk_data: cd, mis: 1'b0, cyc: cyc + lat});
    mem_addr      = a;
    mem_size      = sz;
    memwrite_data = wd;
    mem_rden      = !we || both;
    mem_wren      = we;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (mem_ready) begin got = 1; break; end
    end
    mem_rden = 1'b0;
    mem_wren = 1'b0;
    if (!got) begin
      checks++; failures++;
      $display("FAIL req_timeout: no mem_ready for 0x%08h within 40 cycles, required one", a);
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_ctl"},   {24'd0, mem_ready, mem_misaligned, bus_req, bus_we, bus_be}, 32'd0);
    chk({tag, "_addr"},  bus_addr, 32'd0);
    chk({tag, "_wdata"}, bus_wdata, 32'd0);
    chk({tag, "_rdata"}, memread_data, 32'd0);
  endtask

  initial begin : stim
    bit seen, got;
    rst = 1'b1;
    mem_addr = '0; mem_rden = 1'b0; mem_wren = 1'b0; mem_size = '0; memwrite_data = '0;
    ns_mem_addr = '0; ns_mem_rden = 1'b0; ns_mem_wren = 1'b0; ns_mem_size = '0;
    ns_memwrite_data = '0; ns_bus_gnt = 1'b0; ns_bus_rvalid = 1'b0; ns_bus_rdata = '0;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_outs_zero("reset");
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Aligned word read
    gnt_wait = 0; rv_lat = 1;
    push_bus(1'b0, 32'h100, 4'hF, 32'h0);
    do_req(1'b0, 1'b0, 32'h100, 2'd2, 32'h0, 1'b1, 32'hDEAD_BEEF, 3);

    // Byte store at the top lane
    push_bus(1'b1, 32'h200, 4'b1000, 32'hAB00_0000);
    do_req(1'b1, 1'b0, 32'h203, 2'd0, 32'h0000_00AB, 1'b0, 32'h0, 2);

    // Half read crossing a word
    push_bus(1'b0, 32'h300, 4'b1000, 32'h0);
    push_bus(1'b0, 32'h304, 4'b0001, 32'h0);
    do_req(1'b0, 1'b0, 32'h303, 2'd1, 32'h0, 1'b1, 32'h0000_8811, 5);

    // Word store crossing the top of the address space
    push_bus(1'b1, 32'hFFFF_FFFC, 4'b1100, 32'hBABE_0000);
    push_bus(1'b1, 32'h0000_0000, 4'b0011, 32'h0000_CAFE);
    do_req(1'b1, 1'b0, 32'hFFFF_FFFE, 2'd2, 32'hCAFE_BABE, 1'b0, 32'h0, 3);

    // Split word read, rvalid in the grant cycle
    rv_lat = 0;
    push_bus(1'b0, 32'h300, 4'b1100, 32'h0);
    push_bus(1'b0, 32'h304, 4'b0011, 32'h0);
    do_req(1'b0, 1'b0, 32'h302, 2'd2, 32'h0, 1'b1, 32'h7788_1122, 3);

    // Half store with one grant wait cycle
    rv_lat = 1; gnt_wait = 1;
    push_bus(1'b1, 32'h100, 4'b1100, 32'h1234_0000);
    do_req(1'b1, 1'b0, 32'h102, 2'd1, 32'h0000_1234, 1'b0, 32'h0, 3);

    // Byte read with rvalid two cycles after grant
    gnt_wait = 0; rv_lat = 2;
    push_bus(1'b0, 32'h304, 4'b0010, 32'h0);
    do_req(1'b0, 1'b0, 32'h305, 2'd0, 32'h0, 1'b1, 32'h0000_0077, 4);

    // Read and write together: the write wins
    rv_lat = 1;
    push_bus(1'b1, 32'h000, 4'b0010, 32'h0000_5A00);
    do_req(1'b1, 1'b1, 32'h001, 2'd0, 32'h0000_005A, 1'b0, 32'h0, 2);

    // Rejecting instance: misaligned word read
    ns_q.push_back('{data: 32'h0, chk_data: 1'b1, mis: 1'b1, cyc: cyc + 1});
    ns_mem_addr = 32'h401; ns_mem_size = 2'd2; ns_mem_rden = 1'b1;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ns_mem_ready) begin got = 1; break; end
    end
    ns_mem_rden = 1'b0;
    if (!got) begin
      checks++; failures++;
      $display("FAIL ns_timeout: no mem_ready within 10 cycles, required one");
    end
    repeat (2) @(posedge clk);
    #1;

    // Grant withheld 3 cycles, then reset lands in WAIT0
    gnt_wait = 3; rv_lat = 4;
    push_bus(1'b0, 32'h500, 4'hF, 32'h0);
    mem_addr = 32'h500; mem_size = 2'd2; memwrite_data = '0; mem_rden = 1'b1;
    seen = 0; got = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (seen && !bus_req) begin got = 1; break; end
      if (bus_req) seen = 1;
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL wait0_timeout: never reached WAIT0, required within 20 cycles");
    end
    rst = 1'b0;
    mem_rden = 1'b0;
    #1;
    chk_outs_zero("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!rv_pending) break;
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("post_stale_ready", {31'd0, mem_ready}, 32'd0);
    chk("post_stale_req",   {31'd0, bus_req},   32'd0);

    // Normal request after the abort; size code 3 acts as a word
    gnt_wait = 0; rv_lat = 1;
    push_bus(1'b0, 32'h100, 4'hF, 32'h0);
    do_req(1'b0, 1'b0, 32'h100, 2'd3, 32'h0, 1'b1, 32'hDEAD_BEEF, 3);

    repeat (4) @(posedge clk);
    #1;
    chk("bus_q_left",  32'(bus_q.size()),  32'd0);
    chk("resp_q_left", 32'(resp_q.size()), 32'd0);
    chk("ns_q_left",   32'(ns_q.size()),   32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
